tensor_core_dot_kacc: RTL and testbench

TENSOR_CORE_DOT_KACC -- requirements
Module: tensor_core_dot_kacc

---
 rtl/tensor_core_dot_kacc.sv | 165 ++++++++++++++++
 tb/tb_tensor_core_dot_kacc.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_core_dot_kacc.sv
`default_nettype none
// ============================================================================
// Module   : tensor_core_dot_kacc
// Function : LANES-wide FP16 dot product with an exact Kulisch (fixed-point)
//            group accumulator. Three stages: aligned products, lane-sum
//            adder tree, accumulate. Results have a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tensor_core_dot_kacc #(
  parameter int LANES  = 4,
  parameter int AWIDTH = 92
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [LANES*16-1:0] a_vec,
  input  logic [LANES*16-1:0] b_vec,
  input  logic [AWIDTH-1:0]   c_init,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AWIDTH-1:0]   out_acc,
  output logic                out_exc,
  output logic                out_ovf
);

  logic              w_stall;
  logic              w_accept;
  logic [AWIDTH-1:0] w_prod [LANES];
  logic [LANES-1:0]  w_exc_lane;
  logic [AWIDTH-1:0] w_lane_sum;

  // Unconsumed result freezes the whole pipe; nothing is accepted in reset.
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall & rst_n;
  assign w_accept = in_valid & in_ready;

  // Per-lane exact product, aligned so that the LSB weighs 2^-48.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [15:0]       w_a, w_b;
    logic [10:0]       w_ma, w_mb;
    logic [4:0]        w_ea, w_eb;
    logic [21:0]       w_mp;
    logic [5:0]        w_sh;
    logic              w_inf;
    logic [AWIDTH-1:0] w_mag;

    assign w_a   = a_vec[16*i +: 16];
    assign w_b   = b_vec[16*i +: 16];
    // Subnormals: hidden bit 0 and exponent treated as 1.
    assign w_ma  = {|w_a[14:10], w_a[9:0]};
    assign w_mb  = {|w_b[14:10], w_b[9:0]};
    assign w_ea  = (w_a[14:10] == 5'd0) ? 5'd1 : w_a[14:10];
    assign w_eb  = (w_b[14:10] == 5'd0) ? 5'd1 : w_b[14:10];
    assign w_mp  = {11'd0, w_ma} * {11'd0, w_mb};
    assign w_sh  = {1'b0, w_ea} + {1'b0, w_eb} - 6'd2;
    assign w_inf = (&w_a[14:10]) | (&w_b[14:10]);
    assign w_mag = {{(AWIDTH-22){1'b0}}, w_mp} << w_sh;

    assign w_prod[i]     = w_inf ? '0 : ((w_a[15] ^ w_b[15]) ? -w_mag : w_mag);
    assign w_exc_lane[i] = w_inf;
  end

  // S1 registers
  logic              r_s1_valid, r_s1_first, r_s1_last, r_s1_exc;
  logic [AWIDTH-1:0] r_s1_cinit;
  logic [AWIDTH-1:0] r_s1_prod [LANES];

  // S1: capture aligned products, group markers, exception and c_init.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_exc   <= 1'b0;
      r_s1_cinit <= '0;
      for (int i = 0; i < LANES; i++) r_s1_prod[i] <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      r_s1_first <= in_first;
      r_s1_last  <= in_last;
      r_s1_exc   <= |w_exc_lane;
      r_s1_cinit <= c_init;
      for (int i = 0; i < LANES; i++) r_s1_prod[i] <= w_prod[i];
    end
  end

  // Lane-sum adder tree over the registered products.
  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < LANES; i++) w_lane_sum = w_lane_sum + r_s1_prod[i];
  end

  // S2 registers
  logic              r_s2_valid, r_s2_first, r_s2_last, r_s2_exc;
  logic [AWIDTH-1:0] r_s2_cinit;
  logic [AWIDTH-1:0] r_s2_sum;

  // S2: register the lane sum and forward the beat's side information.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_exc   <= 1'b0;
      r_s2_cinit <= '0;
      r_s2_sum   <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_exc   <= r_s1_exc;
      r_s2_cinit <= r_s1_cinit;
      r_s2_sum   <= w_lane_sum;
    end
  end

  // S3 accumulate
  logic [AWIDTH-1:0] r_acc;
  logic              r_exc_sticky, r_ovf_sticky;
  logic [AWIDTH-1:0] w_base, w_sum;
  logic              w_add_ovf, w_exc_new, w_ovf_new;

  // A first beat restarts from c_init and drops the previous group's flags.
  assign w_base    = r_s2_first ? r_s2_cinit : r_acc;
  assign w_sum     = w_base + r_s2_sum;
  assign w_add_ovf = (w_base[AWIDTH-1] == r_s2_sum[AWIDTH-1]) &&
                     (w_sum[AWIDTH-1] != w_base[AWIDTH-1]);
  assign w_exc_new = (r_s2_first ? 1'b0 : r_exc_sticky) | r_s2_exc;
  assign w_ovf_new = (r_s2_first ? 1'b0 : r_ovf_sticky) | w_add_ovf;

  // S3: accumulator and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_exc_sticky <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else if (!w_stall && r_s2_valid) begin
      r_acc        <= w_sum;
      r_exc_sticky <= w_exc_new;
      r_ovf_sticky <= w_ovf_new;
    end
  end

  // Result register: load on a last beat, hold while stalled, drop on take.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_exc   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (!w_stall && r_s2_valid && r_s2_last) begin
      out_valid <= 1'b1;
      out_acc   <= w_sum;
      out_exc   <= w_exc_new;
      out_ovf   <= w_ovf_new;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tensor_core_dot_kacc.sv
`default_nettype none
// ============================================================================
// Module   : tb_tensor_core_dot_kacc
// Function : Directed self-checking bench for tensor_core_dot_kacc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tensor_core_dot_kacc;

  localparam int LANES  = 4;
  localparam int AWIDTH = 92;
  localparam logic [AWIDTH-1:0] ONE = 92'd1 << 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_first, in_last;
  logic [63:0]       a_vec, b_vec;
  logic [AWIDTH-1:0] c_init;
  logic              out_valid, out_ready, out_exc, out_ovf;
  logic [AWIDTH-1:0] out_acc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tensor_core_dot_kacc #(.LANES(LANES), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .a_vec(a_vec), .b_vec(b_vec), .c_init(c_init),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_exc(out_exc), .out_ovf(out_ovf)
  );

  function automatic logic [63:0] rep4(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  // Present one beat for the coming rising edge.
  task automatic beat(input logic f, input logic l, input logic [63:0] a,
                      input logic [63:0] b, input logic [AWIDTH-1:0] c);
    @(negedge clk);
    in_valid = 1'b1; in_first = f; in_last = l;
    a_vec = a; b_vec = b; c_init = c;
  endtask

  // Drop in_valid and wait (bounded) for the next result.
  task automatic wait_result(output logic [AWIDTH-1:0] acc, output logic exc,
                             output logic ovf, output bit ok);
    ok = 1'b0; acc = '0; exc = 1'b0; ovf = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        acc = out_acc; exc = out_exc; ovf = out_ovf; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a_vec = '0; b_vec = '0; c_init = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_acc !== '0 ||
        out_exc !== 1'b0 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset: valid=%b ready=%b acc=%h exc=%b ovf=%b, want all 0",
               out_valid, in_ready, out_acc, out_exc, out_ovf);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  // Beats without in_first after reset build on acc=0 and ignore c_init.
  task automatic test_no_first();
    logic [AWIDTH-1:0] acc; logic exc, ovf; bit ok;
    beat(1'b0, 1'b1, 64'h3C00, 64'h3C00, 92'h123);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== ONE) begin
      fails++; $display("FAIL no_first_1: ok=%b got %h want %h", ok, acc, ONE);
    end
    beat(1'b0, 1'b1, 64'h3C00, 64'h3C00, 92'h456);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== 2 * ONE) begin
      fails++; $display("FAIL no_first_2: ok=%b got %h want %h", ok, acc, 2 * ONE);
    end
  endtask

  // 4 x (1.0*1.0) with exact three-edge latency.
  task automatic test_ones_latency();
    beat(1'b1, 1'b1, rep4(16'h3C00), rep4(16'h3C00), '0);
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL latency_e1: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL latency_e2: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_acc !== 4 * ONE || out_exc !== 1'b0 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ones_result: valid=%b acc=%h exc=%b ovf=%b want 1 %h 0 0",
               out_valid, out_acc, out_exc, out_ovf, 4 * ONE);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL valid_clear: out_valid=%b want 0", out_valid);
    end
  endtask

  // Mixed signs, a subnormal, the largest shift and a negative product.
  task automatic test_mixed();
    logic [AWIDTH-1:0] acc; logic exc, ovf; bit ok;
    logic [AWIDTH-1:0] exp_max;
    beat(1'b1, 1'b1, {16'h3C00, 16'hBC00, 16'h4000, 16'h0000}, rep4(16'h3C00), '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== 2 * ONE) begin
      fails++; $display("FAIL mixed_signs: ok=%b got %h want %h", ok, acc, 2 * ONE);
    end
    beat(1'b1, 1'b1, 64'h0001, 64'h0001, '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== 92'd1) begin
      fails++; $display("FAIL subnormal: ok=%b got %h want 1", ok, acc);
    end
    exp_max = 92'd4190209 << 58;
    beat(1'b1, 1'b1, 64'h7BFF, 64'h7BFF, '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== exp_max || exc !== 1'b0 || ovf !== 1'b0) begin
      fails++; $display("FAIL max_shift: ok=%b got %h want %h", ok, acc, exp_max);
    end
    beat(1'b1, 1'b1, 64'hBC00, 64'h3C00, '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== -ONE) begin
      fails++; $display("FAIL negative: ok=%b got %h want %h", ok, acc, -ONE);
    end
  endtask

  // Three beats of 4.0 on top of c_init=1.0 form one result of 13.0.
  task automatic test_multi_beat();
    logic [AWIDTH-1:0] acc; logic exc, ovf; bit ok;
    beat(1'b1, 1'b0, rep4(16'h3C00), rep4(16'h3C00), ONE);
    beat(1'b0, 1'b0, rep4(16'h3C00), rep4(16'h3C00), '0);
    beat(1'b0, 1'b1, rep4(16'h3C00), rep4(16'h3C00), '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== 13 * ONE || exc !== 1'b0) begin
      fails++; $display("FAIL multi_beat: ok=%b got %h exc=%b want %h exc=0",
                        ok, acc, exc, 13 * ONE);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL multi_beat_single: out_valid=%b want 0", out_valid);
    end
  endtask

  // Inf in one lane zeroes that product and flags the group only.
  task automatic test_exception();
    logic [AWIDTH-1:0] acc; logic exc, ovf; bit ok;
    beat(1'b1, 1'b1, {16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00}, rep4(16'h3C00), '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== 3 * ONE || exc !== 1'b1) begin
      fails++; $display("FAIL exc_set: ok=%b got %h exc=%b want %h exc=1",
                        ok, acc, exc, 3 * ONE);
    end
    beat(1'b1, 1'b1, rep4(16'h3C00), rep4(16'h3C00), '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== 4 * ONE || exc !== 1'b0) begin
      fails++; $display("FAIL exc_clear: ok=%b got %h exc=%b want %h exc=0",
                        ok, acc, exc, 4 * ONE);
    end
  endtask

  // Signed overflow wraps and flags; the next group starts clean.
  task automatic test_overflow();
    logic [AWIDTH-1:0] acc; logic exc, ovf; bit ok;
    logic [AWIDTH-1:0] cmax, exp_wrap;
    cmax     = {1'b0, {(AWIDTH-1){1'b1}}};
    exp_wrap = cmax + (4 * ONE);
    beat(1'b1, 1'b1, rep4(16'h3C00), rep4(16'h3C00), cmax);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== exp_wrap || ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_set: ok=%b got %h ovf=%b want %h ovf=1",
                        ok, acc, ovf, exp_wrap);
    end
    beat(1'b1, 1'b1, rep4(16'h3C00), rep4(16'h3C00), '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== 4 * ONE || ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_clear: ok=%b got %h ovf=%b want %h ovf=0",
                        ok, acc, ovf, 4 * ONE);
    end
  endtask

  // Single-beat groups every cycle give results every cycle.
  task automatic test_back_to_back();
    logic [AWIDTH-1:0] exp_v;
    for (int g = 0; g < 3; g++) beat(1'b1, 1'b1, '0, '0, 92'(100 + g));
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    for (int g = 0; g < 3; g++) begin
      exp_v = 92'(100 + g);
      tests++;
      if (out_valid !== 1'b1 || out_acc !== exp_v) begin
        fails++; $display("FAIL b2b_%0d: valid=%b acc=%h want 1 %h", g, out_valid, out_acc, exp_v);
      end
      @(negedge clk);
    end
  endtask

  // Five cycles of back-pressure under a continuous stream.
  task automatic test_stall();
    int sent = 0;
    int got  = 0;
    bit held_v = 1'b0;
    logic [AWIDTH-1:0] held = '0;
    logic [AWIDTH-1:0] exp_v;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 8);
      #1;
      if (out_valid && !out_ready) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++; $display("FAIL stall_ready: in_ready=%b want 0 at cyc %0d", in_ready, cyc);
        end
        if (held_v) begin
          tests++;
          if (out_acc !== held) begin
            fails++; $display("FAIL stall_hold: acc=%h want %h", out_acc, held);
          end
        end
        held = out_acc; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        exp_v = 92'(got * 7 + 3);
        tests++;
        if (out_acc !== exp_v) begin
          fails++; $display("FAIL stall_order_%0d: acc=%h want %h", got, out_acc, exp_v);
        end
        got++;
      end
      if (sent < 6) begin
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        a_vec = '0; b_vec = '0; c_init = 92'(sent * 7 + 3);
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests++;
    if (got != 6) begin
      fails++; $display("FAIL stall_count: got %0d results want 6", got);
    end
  endtask

  // Reset in the middle of a group discards it.
  task automatic test_reset_mid_group();
    logic [AWIDTH-1:0] acc; logic exc, ovf; bit ok;
    bit seen = 1'b0;
    beat(1'b1, 1'b0, rep4(16'h3C00), rep4(16'h3C00), 92'd5);
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL rst_ready: in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL rst_discard: out_valid seen=1 want 0");
    end
    beat(1'b1, 1'b1, 64'h3C00, 64'h3C00, '0);
    wait_result(acc, exc, ovf, ok);
    tests++;
    if (!ok || acc !== ONE || exc !== 1'b0 || ovf !== 1'b0) begin
      fails++; $display("FAIL rst_next_group: ok=%b got %h want %h", ok, acc, ONE);
    end
  endtask

  initial begin
    test_reset();
    test_no_first();
    test_ones_latency();
    test_mixed();
    test_multi_beat();
    test_exception();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_mid_group();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
